// File: rtl/uart_prog_loader_pkg.sv
// Shared types and constants for the UART program loader and its byte receiver.
package uart_prog_loader_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    typedef enum logic [1:0] {
        LD_RUN,
        LD_LOAD,
        LD_DRAIN
    } ld_state_e;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BYTE_IDX_W     = $clog2(BYTES_PER_WORD);
    localparam int unsigned PART_W         = 8 * (BYTES_PER_WORD - 1);

endpackage

// File: rtl/uart_prog_loader_rx.sv
// 8N1 UART byte receiver, LSB first, mid-bit sampling on an already synchronised line.
module uart_rx_byte
    import uart_prog_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_sync,
    input  logic       clr,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err
);

    localparam int unsigned     CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);

    rx_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic             prev_q;
    logic             valid_q;
    logic             ferr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            prev_q  <= 1'b1;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            prev_q  <= rx_sync;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            if (clr) begin
                state_q <= RX_IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    RX_IDLE: begin
                        if (prev_q && !rx_sync) begin
                            state_q <= RX_START;
                            cnt_q   <= '0;
                        end
                    end
                    RX_START: begin
                        // Line must still be low half a bit after the edge, else it was a glitch.
                        if (cnt_q == HALF_END) begin
                            cnt_q   <= '0;
                            bit_q   <= '0;
                            state_q <= rx_sync ? RX_IDLE : RX_DATA;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    RX_DATA: begin
                        if (cnt_q == BIT_END) begin
                            cnt_q   <= '0;
                            shift_q <= {rx_sync, shift_q[7:1]};
                            if (bit_q == 3'd7) begin
                                state_q <= RX_STOP;
                            end else begin
                                bit_q <= bit_q + 3'd1;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    RX_STOP: begin
                        if (cnt_q == BIT_END) begin
                            cnt_q   <= '0;
                            state_q <= RX_IDLE;
                            if (rx_sync) begin
                                valid_q <= 1'b1;
                            end else begin
                                ferr_q <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    default: state_q <= RX_IDLE;
                endcase
            end
        end
    end

    assign rx_valid  = valid_q;
    assign rx_byte   = shift_q;
    assign frame_err = ferr_q;

endmodule

// File: rtl/uart_prog_loader.sv
// UART boot loader: holds the CPU in reset while prog_mode is high and streams
// received bytes, packed big-endian into 32-bit words, into instruction memory.
module uart_prog_loader
    import uart_prog_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned ADDR_W       = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_rx,
    input  logic              prog_mode,
    output logic              cpu_rst_o,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              loading,
    output logic [ADDR_W:0]   word_cnt,
    output logic              err_frame,
    output logic              err_ovf
);

    logic rx_meta_q, rx_sync_q;
    logic pm_meta_q, pm_sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            pm_meta_q <= 1'b0;
            pm_sync_q <= 1'b0;
        end else begin
            rx_meta_q <= uart_rx;
            rx_sync_q <= rx_meta_q;
            pm_meta_q <= prog_mode;
            pm_sync_q <= pm_meta_q;
        end
    end

    ld_state_e             state_q;
    logic                  cpu_rst_q;
    logic                  we_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [31:0]           wdata_q;
    logic                  loading_q;
    logic [ADDR_W:0]       word_cnt_q;
    logic [ADDR_W-1:0]     ptr_q;
    logic                  err_frame_q;
    logic                  err_ovf_q;
    logic [BYTE_IDX_W-1:0] byte_idx_q;
    logic [PART_W-1:0]     word_q;

    logic                  rx_valid;
    logic [7:0]            rx_byte;
    logic                  rx_frame_err;
    logic                  rx_clr;

    logic [PART_W-1:0]     word_d;
    logic [31:0]           full_word_d;
    logic                  last_byte;
    logic                  mem_full;

    assign rx_clr = (state_q == LD_DRAIN);

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk      (clk),
        .rst      (rst),
        .rx_sync  (rx_sync_q),
        .clr      (rx_clr),
        .rx_valid (rx_valid),
        .rx_byte  (rx_byte),
        .frame_err(rx_frame_err)
    );

    always_comb begin
        word_d      = {word_q[PART_W-9:0], rx_byte};
        full_word_d = {word_q, rx_byte};
        last_byte   = (byte_idx_q == BYTE_IDX_W'(BYTES_PER_WORD - 1));
        // Count has reached 2^ADDR_W exactly when its top bit is set.
        mem_full    = word_cnt_q[ADDR_W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= LD_RUN;
            cpu_rst_q   <= 1'b1;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            loading_q   <= 1'b0;
            word_cnt_q  <= '0;
            ptr_q       <= '0;
            err_frame_q <= 1'b0;
            err_ovf_q   <= 1'b0;
            byte_idx_q  <= '0;
            word_q      <= '0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                LD_RUN: begin
                    if (pm_sync_q) begin
                        state_q     <= LD_LOAD;
                        cpu_rst_q   <= 1'b1;
                        loading_q   <= 1'b1;
                        word_cnt_q  <= '0;
                        ptr_q       <= '0;
                        addr_q      <= '0;
                        byte_idx_q  <= '0;
                        word_q      <= '0;
                        err_frame_q <= 1'b0;
                        err_ovf_q   <= 1'b0;
                    end else begin
                        cpu_rst_q <= 1'b0;
                    end
                end
                LD_LOAD: begin
                    // A byte completing on the exit cycle is dropped; a write strobed last cycle still lands.
                    if (!pm_sync_q) begin
                        state_q    <= LD_DRAIN;
                        loading_q  <= 1'b0;
                        byte_idx_q <= '0;
                    end else begin
                        if (rx_frame_err) begin
                            err_frame_q <= 1'b1;
                        end
                        if (rx_valid) begin
                            if (last_byte) begin
                                byte_idx_q <= '0;
                                if (mem_full) begin
                                    err_ovf_q <= 1'b1;
                                end else begin
                                    we_q       <= 1'b1;
                                    addr_q     <= ptr_q;
                                    wdata_q    <= full_word_d;
                                    ptr_q      <= ptr_q + ADDR_W'(1);
                                    word_cnt_q <= word_cnt_q + (ADDR_W + 1)'(1);
                                end
                            end else begin
                                word_q     <= word_d;
                                byte_idx_q <= byte_idx_q + BYTE_IDX_W'(1);
                            end
                        end
                    end
                end
                LD_DRAIN: begin
                    state_q   <= LD_RUN;
                    cpu_rst_q <= 1'b0;
                end
                default: begin
                    state_q   <= LD_RUN;
                    cpu_rst_q <= 1'b1;
                    loading_q <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_rst_o  = cpu_rst_q;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign loading    = loading_q;
    assign word_cnt   = word_cnt_q;
    assign err_frame  = err_frame_q;
    assign err_ovf    = err_ovf_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader: table-driven load sessions plus overflow,
// framing-error and mid-word reset sequences.
module tb_uart_prog_loader;

    localparam int unsigned CPB = 16;
    localparam int unsigned AW  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          uart_rx;
    logic          prog_mode;
    logic          cpu_rst_o;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          loading;
    logic [AW:0]   word_cnt;
    logic          err_frame;
    logic          err_ovf;

    always #10 clk = ~clk;

    uart_prog_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W      (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .uart_rx   (uart_rx),
        .prog_mode (prog_mode),
        .cpu_rst_o (cpu_rst_o),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .loading   (loading),
        .word_cnt  (word_cnt),
        .err_frame (err_frame),
        .err_ovf   (err_ovf)
    );

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] wr_addr_q [$];
    logic [31:0]   wr_data_q [$];
    int            long_pulses = 0;
    logic          we_prev = 1'b0;

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_addr_q.push_back(imem_addr);
            wr_data_q.push_back(imem_wdata);
            if (we_prev) long_pulses++;
        end
        we_prev = (imem_we === 1'b1);
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int unsigned nbytes;
        logic [95:0] bytes;
        int unsigned exp_writes;
        logic [31:0] exp_w0;
        logic [31:0] exp_w1;
        int unsigned exp_cnt;
    } sess_t;

    sess_t tbl [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_writes();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic enter_load(input string name);
        int n;
        @(negedge clk);
        prog_mode = 1'b1;
        n = 0;
        while (loading !== 1'b1 && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_enter_latency"}, 32'(n), 32'd3);
        chk({name, "_enter_cpu_rst"}, 32'(cpu_rst_o), 32'd1);
        chk({name, "_enter_wcnt"}, 32'(word_cnt), 32'd0);
    endtask

    task automatic leave_load(input string name);
        int n;
        repeat (4) @(negedge clk);
        prog_mode = 1'b0;
        n = 0;
        while (cpu_rst_o !== 1'b0 && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        // Two sync stages, then DRAIN, then release: four edges after the input drops.
        chk({name, "_release_latency"}, 32'(n), 32'd4);
        chk({name, "_loading_off"}, 32'(loading), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [95:0] bv;
        logic [31:0] one_word;
        int n;

        rst       = 1'b1;
        uart_rx   = 1'b1;
        prog_mode = 1'b0;

        #45;
        chk("rst_cpu_rst", 32'(cpu_rst_o), 32'd1);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_loading", 32'(loading), 32'd0);
        chk("rst_wcnt", 32'(word_cnt), 32'd0);
        chk("rst_err_frame", 32'(err_frame), 32'd0);
        chk("rst_err_ovf", 32'(err_ovf), 32'd0);
        #10;
        rst = 1'b0;
        n = 0;
        while (cpu_rst_o !== 1'b0 && n < 3) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("por_cpu_rst_release", 32'(cpu_rst_o), 32'd0);
        repeat (5) @(negedge clk);
        chk("por_no_write", 32'(wr_addr_q.size()), 32'd0);

        tbl[0] = '{4, 96'h12345678_00000000_00000000, 1, 32'h12345678, 32'h0, 1};
        tbl[1] = '{9, 96'h00010203_04050607_08000000, 2, 32'h00010203, 32'h04050607, 2};
        tbl[2] = '{3, 96'hAABBCC00_00000000_00000000, 0, 32'h0, 32'h0, 0};
        tbl[3] = '{6, 96'hDEADBEEF_01020000_00000000, 1, 32'hDEADBEEF, 32'h0, 1};
        tbl[4] = '{8, 96'hCAFEBABE_0F1E2D3C_00000000, 2, 32'hCAFEBABE, 32'h0F1E2D3C, 2};

        for (int s = 0; s < 5; s++) begin
            string nm;
            nm = $sformatf("s%0d", s);
            clear_writes();
            enter_load(nm);
            bv = tbl[s].bytes;
            for (int j = 0; j < int'(tbl[s].nbytes); j++) begin
                send_byte(bv[95 - 8*j -: 8], 1'b1);
            end
            leave_load(nm);
            chk({nm, "_nwrites"}, 32'(wr_addr_q.size()), 32'(tbl[s].exp_writes));
            if (wr_addr_q.size() > 0 && tbl[s].exp_writes > 0) begin
                chk({nm, "_addr0"}, 32'(wr_addr_q[0]), 32'd0);
                chk({nm, "_data0"}, wr_data_q[0], tbl[s].exp_w0);
            end
            if (wr_addr_q.size() > 1 && tbl[s].exp_writes > 1) begin
                chk({nm, "_addr1"}, 32'(wr_addr_q[1]), 32'd1);
                chk({nm, "_data1"}, wr_data_q[1], tbl[s].exp_w1);
            end
            chk({nm, "_wcnt"}, 32'(word_cnt), 32'(tbl[s].exp_cnt));
            chk({nm, "_err_frame"}, 32'(err_frame), 32'd0);
            chk({nm, "_err_ovf"}, 32'(err_ovf), 32'd0);
        end

        // Overflow: 17 words into a 16-word memory.
        clear_writes();
        enter_load("ovf");
        for (int w = 0; w < 16; w++) begin
            for (int k = 0; k < 4; k++) send_byte(8'(w), 1'b1);
        end
        chk("ovf_wcnt_full", 32'(word_cnt), 32'd16);
        chk("ovf_flag_before", 32'(err_ovf), 32'd0);
        for (int k = 0; k < 4; k++) send_byte(8'h10, 1'b1);
        chk("ovf_flag_after", 32'(err_ovf), 32'd1);
        chk("ovf_wcnt_hold", 32'(word_cnt), 32'd16);
        chk("ovf_loading", 32'(loading), 32'd1);
        leave_load("ovf");
        chk("ovf_nwrites", 32'(wr_addr_q.size()), 32'd16);
        for (int w = 0; w < 16; w++) begin
            if (w < wr_addr_q.size()) begin
                chk($sformatf("ovf_addr%0d", w), 32'(wr_addr_q[w]), 32'(w));
                chk($sformatf("ovf_data%0d", w), wr_data_q[w], 32'(w) * 32'h01010101);
            end
        end

        // Framing error, then a good word, then the flag clears on re-entry.
        clear_writes();
        enter_load("ferr");
        chk("ferr_ovf_cleared", 32'(err_ovf), 32'd0);
        send_byte(8'h55, 1'b0);
        chk("ferr_flag", 32'(err_frame), 32'd1);
        chk("ferr_no_byte", 32'(word_cnt), 32'd0);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        chk("ferr_flag_sticky", 32'(err_frame), 32'd1);
        leave_load("ferr");
        chk("ferr_nwrites", 32'(wr_addr_q.size()), 32'd1);
        one_word = (wr_data_q.size() > 0) ? wr_data_q[0] : 32'hxxxxxxxx;
        chk("ferr_data0", one_word, 32'h11223344);
        chk("ferr_wcnt", 32'(word_cnt), 32'd1);
        enter_load("ferr2");
        chk("ferr_cleared", 32'(err_frame), 32'd0);
        leave_load("ferr2");
        chk("ferr2_nwrites", 32'(wr_addr_q.size()), 32'd1);

        // Reset mid-word and mid-frame.
        clear_writes();
        enter_load("rmw");
        send_byte(8'h5A, 1'b1);
        send_byte(8'h5B, 1'b1);
        send_byte(8'h5C, 1'b1);
        send_byte(8'h5D, 1'b1);
        chk("rmw_pre_wcnt", 32'(word_cnt), 32'd1);
        send_byte(8'h66, 1'b1);
        send_byte(8'h77, 1'b1);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (40) @(negedge clk);
        #3;
        rst       = 1'b1;
        prog_mode = 1'b0;
        #1;
        chk("rmw_cpu_rst", 32'(cpu_rst_o), 32'd1);
        chk("rmw_we", 32'(imem_we), 32'd0);
        chk("rmw_addr", 32'(imem_addr), 32'd0);
        chk("rmw_wdata", imem_wdata, 32'd0);
        chk("rmw_loading", 32'(loading), 32'd0);
        chk("rmw_wcnt", 32'(word_cnt), 32'd0);
        uart_rx = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        clear_writes();
        enter_load("rmw2");
        send_byte(8'hA1, 1'b1);
        send_byte(8'hB2, 1'b1);
        send_byte(8'hC3, 1'b1);
        send_byte(8'hD4, 1'b1);
        leave_load("rmw2");
        chk("rmw2_nwrites", 32'(wr_addr_q.size()), 32'd1);
        one_word = (wr_data_q.size() > 0) ? wr_data_q[0] : 32'hxxxxxxxx;
        chk("rmw2_data0", one_word, 32'hA1B2C3D4);
        one_word = (wr_addr_q.size() > 0) ? 32'(wr_addr_q[0]) : 32'hxxxxxxxx;
        chk("rmw2_addr0", one_word, 32'd0);
        chk("rmw2_wcnt", 32'(word_cnt), 32'd1);

        chk("we_single_cycle", 32'(long_pulses), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- UART boot/program loader sitting directly upstream of the CPU core.
- It owns the CPU's reset input and the instruction-memory write port.
- While program mode is requested, it holds the CPU in reset, receives a byte stream over UART RX, packs it into 32-bit words and writes them into instruction memory from word address 0.
- When program mode is dropped, it releases the CPU to run from address 0.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); minimum 8.
- ADDR_W, 14, instruction-memory word-address width.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- uart_rx  input  1  asynchronous serial input; idles high; 8N1, LSB first.
- prog_mode  input  1  asynchronous level; high requests loading.
- cpu_rst_o  output  1  reset to CPU core; active-high.
- imem_we  output  1  one-cycle instruction-memory write strobe.
- imem_addr  output  ADDR_W  word address for the write.
- imem_wdata  output  32  word to write.
- loading  output  1  high while in LOAD.
- word_cnt  output  ADDR_W+1  words written since the last LOAD entry.
- err_frame  output  1  sticky: a stop bit was sampled low.
- err_ovf  output  1  sticky: a word arrived after the memory was full.

Behaviour:
- Reset, asynchronous, rst high:
  - cpu_rst_o=1; imem_we=0; imem_addr=0; imem_wdata=0; loading=0; word_cnt=0; err_frame=0; err_ovf=0; state=RUN; byte index=0; RX FSM=IDLE.
  - Reset may occur mid-frame or mid-word; all partial data is discarded.
- After rst falls: cpu_rst_o drops on the first clk edge at which synced prog_mode=0.
- Synchronisers: uart_rx and prog_mode each pass through 2 flops; all logic uses the synced versions.
- Loader FSM: RUN -> LOAD -> DRAIN -> RUN.
  - RUN: cpu_rst_o=0.
    - synced prog_mode=1 -> LOAD next cycle.
    - On entry to LOAD: cpu_rst_o=1, word_cnt=0, imem_addr pointer=0, byte index=0, err_frame=0, err_ovf=0.
  - LOAD: cpu_rst_o=1, loading=1.
    - Each valid RX byte shifts into the word, big-endian: the first byte goes to [31:24].
    - On the 4th byte: the cycle after rx_valid, imem_we=1 for exactly 1 cycle with imem_addr=pointer and imem_wdata=word.
    - After that write: pointer+1, word_cnt+1, byte index->0.
  - Overflow: when word_cnt == 2^ADDR_W, further complete words are not written; err_ovf=1 and word_cnt holds.
  - LOAD with synced prog_mode=0 -> DRAIN.
    - A partial word (1-3 bytes) is discarded.
    - A write already scheduled for this cycle still completes.
  - DRAIN: 1 cycle; cpu_rst_o=1; RX FSM forced to IDLE; -> RUN.
  - Net effect: cpu_rst_o falls 2 cycles after synced prog_mode falls.
- RX FSM (sub-module): IDLE, START, DATA, STOP.
  - IDLE: a falling edge on synced rx -> START, counter=0.
  - START: at CLKS_PER_BIT/2, rx still low -> DATA; otherwise a glitch -> IDLE.
  - DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first.
  - STOP: sample after CLKS_PER_BIT.
    - High -> rx_valid=1 for 1 cycle with rx_byte.
    - Low -> no rx_valid; frame_err pulse, which sets err_frame only in LOAD.
    - Either way -> IDLE; IDLE accepts a new start edge on the next cycle.
  - Bytes received in RUN are ignored by the loader.
- Simultaneous events: rx_valid on the same cycle LOAD is exited is ignored. A prog_mode re-assert while in DRAIN is handled in RUN, so it re-enters LOAD one cycle later.

Decomposition:
- Shared package: RX state encoding, loader state encoding (RUN/LOAD/DRAIN), BYTES_PER_WORD=4.
- One sub-module: uart_rx_byte, with ports clk, rst, rx_sync, clr, rx_valid, rx_byte[7:0], frame_err, and parameter CLKS_PER_BIT.
- The synchronisers and packing logic stay in the top module.

Test Plan:
- Reset release, prog_mode=0:
  - Hold rst for 50 ns at a 20 ns clock -> cpu_rst_o=1 during reset.
  - cpu_rst_o=0 within 3 cycles after rst falls; imem_we never pulses.
- Single word, CLKS_PER_BIT=16, ADDR_W=4:
  - Raise prog_mode; send 0x12,0x34,0x56,0x78; drop prog_mode.
  - Expect one imem_we pulse with addr=0, data=0x12345678; word_cnt=1.
  - cpu_rst_o falls 2 cycles after synced prog_mode falls.
- Multi-word and partial discard: send 9 bytes 0x00..0x08.
  - Writes: addr0=0x00010203, addr1=0x04050607.
  - The trailing 0x08 is discarded; word_cnt=2.
- Overflow, ADDR_W=4: send 17 words.
  - 16 writes to addr 0..15; the 17th is not written; err_ovf=1; word_cnt=16.
- Frame error: in LOAD, send a byte with stop bit low.
  - No rx_valid; err_frame=1.
  - The next good 4 bytes still form word 0.
  - err_frame clears on the next LOAD entry.
- Reset mid-word: assert rst after 2 bytes.
  - All outputs return to reset values immediately.
  - After re-entering LOAD, 4 new bytes write addr0 with those bytes only.
